muldiv_hilo: RTL

MULDIV_HILO -- requirements
Module: muldiv_hilo

---
 rtl/muldiv_hilo.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/muldiv_hilo.sv
// Iterative HI/LO multiply/divide unit (shift-add MUL, restoring DIV), one bit per cycle.
// Latency: WIDTH+1 busy cycles, then a one-cycle done pulse; start/MTHI/MTLO are ignored while busy.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               signed_op, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   quot, rem;

  assign signed_op = ~op[0];
  assign sign_a    = signed_op & a[WIDTH-1];
  assign sign_b    = signed_op & b[WIDTH-1];
  assign mag_a     = sign_a ? -a : a;
  assign mag_b     = sign_b ? -b : b;

  // acc holds {partial product, remaining multiplier} in MUL and {remainder, dividend/quotient} in DIV.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_diff = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_q};
  assign div_ok   = ~div_diff[WIDTH+1];
  assign quot     = acc_q[WIDTH-1:0];
  assign rem      = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = op[1] ? DIV : MUL;
          busy_d    = 1'b1;
          cnt_d     = '0;
          is_div_d  = op[1];
          opnd_d    = op[1] ? mag_b : mag_a;
          acc_d     = op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      DIV: begin
        if (div_ok) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (is_div_q) begin
          // A zero divisor leaves the dividend magnitude in rem, so the sign fix restores the raw a.
          dbz_d = (opnd_q == '0);
          hi_d  = neg_rem_q ? -rem : rem;
          lo_d  = (opnd_q == '0) ? '1 : (neg_res_q ? -quot : quot);
        end else begin
          {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
